// File: rtl/sprite_pkg.sv
// Shared widths, arbiter states and the read-tag record for the sprite ROM arbiter.
package sprite_pkg;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 12;
    localparam int ROM_LAT = 1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    // One in-flight read: valid flag plus the requester it belongs to.
    typedef struct packed {
        logic valid;
        logic id;
    } rom_tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Valid+ID delay line that keeps each accepted read's owner aligned with the ROM data.
module rom_tag_pipe
    import sprite_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    rom_tag_t tag_in;
    rom_tag_t tag_reg [DEPTH];

    assign tag_in = '{valid: in_valid, id: in_id};

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            rom_tag_t tag_next;

            if (gi == 0) begin : g_head
                assign tag_next = tag_in;
            end else begin : g_tail
                assign tag_next = tag_reg[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tag_reg[gi] <= '0;
                end else begin
                    tag_reg[gi] <= tag_next;
                end
            end
        end
    endgenerate

    assign out_valid = tag_reg[DEPTH-1].valid;
    assign out_id    = tag_reg[DEPTH-1].id;

endmodule

// File: rtl/sprite_rom_arb.sv
// Two-requester sprite ROM arbiter: round-robin with optional burst lock, fixed-latency returns.
module sprite_rom_arb
    import sprite_pkg::*;
#(
    parameter int ADDR_W   = sprite_pkg::ADDR_W,
    parameter int DATA_W   = sprite_pkg::DATA_W,
    parameter int ROM_LAT  = sprite_pkg::ROM_LAT,
    parameter int MAX_LOCK = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout
);

    localparam int              CNT_W    = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    arb_state_t       state_reg, state_next;
    logic             prio_reg, prio_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic [CNT_W-1:0] lock_cnt_inc;

    logic accept;
    logic tag_valid;
    logic tag_id;

    // Grants are combinational so a requester sees acceptance in the same cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            case (state_reg)
                ARB: begin
                    if (req0 && (!req1 || !prio_reg)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end
                end
                LOCK0:   gnt0 = req0;
                LOCK1:   gnt1 = req1;
                default: ;
            endcase
        end
    end

    assign accept       = gnt0 | gnt1;
    assign lock_cnt_inc = (lock_cnt_reg == LOCK_MAX) ? lock_cnt_reg : lock_cnt_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        prio_next     = prio_reg;
        lock_cnt_next = lock_cnt_reg;
        case (state_reg)
            ARB: begin
                if (accept) begin
                    prio_next = gnt0;
                    if (gnt0 && lock0) begin
                        state_next    = LOCK0;
                        lock_cnt_next = CNT_W'(1);
                    end else if (gnt1 && lock1) begin
                        state_next    = LOCK1;
                        lock_cnt_next = CNT_W'(1);
                    end
                end
            end
            LOCK0: begin
                if (gnt0) begin
                    lock_cnt_next = lock_cnt_inc;
                end
                if (!req0 || !lock0) begin
                    state_next = ARB;
                end else if (lock_cnt_next == LOCK_MAX) begin
                    state_next = ARB;
                    prio_next  = 1'b1;
                end
            end
            LOCK1: begin
                if (gnt1) begin
                    lock_cnt_next = lock_cnt_inc;
                end
                if (!req1 || !lock1) begin
                    state_next = ARB;
                end else if (lock_cnt_next == LOCK_MAX) begin
                    state_next = ARB;
                    prio_next  = 1'b0;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ARB;
            prio_reg     <= 1'b0;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            prio_reg     <= prio_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // rom_addr only moves on an accepted read so an idle ROM sees a stable address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
        end else begin
            rom_en <= accept;
            if (accept) begin
                rom_addr <= gnt1 ? addr1 : addr0;
            end
        end
    end

    rom_tag_pipe #(
        .DEPTH (ROM_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_id     (gnt1),
        .out_valid (tag_valid),
        .out_id    (tag_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_valid && !tag_id;
            rvalid1 <= tag_valid && tag_id;
            if (tag_valid && !tag_id) begin
                rdata0 <= rom_dout;
            end
            if (tag_valid && tag_id) begin
                rdata1 <= rom_dout;
            end
        end
    end

endmodule

// File: doc/sprite_rom_arb.md
SPRITE_ROM_ARB -- requirements
Module: sprite_rom_arb

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameters SHALL be, one per line:
 ADDR_W, 20, ROM address width.
 DATA_W, 12, ROM pixel width (RGB444).
 ROM_LAT, 1, ROM read latency in cycles (1..4).
 MAX_LOCK, 256, maximum consecutive locked grants.
REQ-003 Ports SHALL be, one per line:
 clk  in  1  system/pixel clock.
 rst  in  1  asynchronous active-low reset.
 req0  in  1  requester 0 (tom drawer) read request.
 lock0  in  1  requester 0 burst-lock request.
 addr0  in  ADDR_W  requester 0 address.
 gnt0  out  1  requester 0 grant, combinational.
 rdata0  out  DATA_W  requester 0 returned pixel.
 rvalid0  out  1  rdata0 valid, one-cycle pulse.
 req1, lock1, addr1, gnt1, rdata1, rvalid1: same as above, for requester 1 (jerry drawer).
 rom_en  out  1  ROM read strobe, registered.
 rom_addr  out  ADDR_W  ROM address, registered.
 rom_dout  in  DATA_W  ROM data, valid ROM_LAT cycles after rom_en.

Function
REQ-004 A read SHALL be accepted in cycle N when reqX and gntX are both 1; at most one gnt SHALL be 1 per cycle.
REQ-005 gntX SHALL NOT be 1 while reqX is 0.
REQ-006 An accepted read SHALL drive rom_en=1 and rom_addr=addrX in cycle N+1; otherwise rom_en SHALL be 0 and rom_addr SHALL hold its value.
REQ-007 rdataX/rvalidX SHALL be registered and SHALL pulse in cycle N+ROM_LAT+2 (3 cycles for ROM_LAT=1), using the requester ID carried through a valid+ID delay line.
REQ-008 Back-to-back accepts SHALL give one read per cycle with no bubbles, and returns SHALL stay in order.
REQ-009 The FSM states SHALL be ARB, LOCK0, LOCK1.
REQ-010 In ARB with a single requester, that requester SHALL be granted.
REQ-011 In ARB with both requesting, the side selected by the 1-bit prio pointer SHALL be granted; after any ARB grant to X, prio SHALL point to the other side.
REQ-012 In ARB, an accept by X with lockX=1 SHALL move the FSM to LOCKX and load lock_cnt=1.
REQ-013 In LOCKX, gntX SHALL equal reqX and the other gnt SHALL be 0.
REQ-014 In LOCKX, each accept SHALL increment lock_cnt, saturating at MAX_LOCK.
REQ-015 LOCKX SHALL return to ARB at the next edge when reqX=0 or lockX=0.
REQ-016 LOCKX SHALL also return to ARB at the next edge when lock_cnt reaches MAX_LOCK; on that forced exit prio SHALL point to the other side.
REQ-017 The grant and address from REQ-013 SHALL still apply in the exit cycle.
REQ-018 Deasserting reqX after acceptance SHALL NOT cancel that read's return.
REQ-019 rdata0/rdata1 SHALL hold their last value when not valid.

Reset
REQ-020 While rst=0, the following SHALL hold: FSM=ARB, prio=0, lock_cnt=0, rom_en=0, rom_addr=0, delay line cleared, rvalid0=rvalid1=0, rdata0=rdata1=0.
REQ-021 Reset mid-operation SHALL discard all in-flight reads, with no rvalid pulse after release for reads accepted before reset.
REQ-022 gnt0/gnt1 SHALL be 0 while rst=0.

Structure
REQ-023 Package sprite_pkg SHALL hold ADDR_W, DATA_W, ROM_LAT and the typedef arb_state_t {ARB, LOCK0, LOCK1}.
REQ-024 The ROM_LAT+1 stage valid+ID delay line SHALL be a sub-module named rom_tag_pipe; the FSM, prio and lock_cnt SHALL live in sprite_rom_arb.

Verification
REQ-025 The bench SHALL cover at least these scenarios:
 a. Single request: req0=1, addr0=0x00010 for 1 cycle -> gnt0=1 same cycle; rom_en=1, rom_addr=0x00010 next cycle; rvalid0 pulses 3 cycles after accept with the ROM word; rvalid1 stays 0.
 b. Round-robin: req0=req1=1 constant for 6 cycles after reset -> grants 0,1,0,1,0,1; returns alternate rvalid0/rvalid1 in order.
 c. Lock: lock1=req1=1 with req0=1 for 10 cycles -> gnt1 for all 10, gnt0=0; lock1 drops -> next grant goes to requester 0.
 d. Lock timeout with MAX_LOCK=4: lock0=req0=req1=1 held -> 4 gnt0, then gnt1 one cycle, then prio rules resume.
 e. Reset mid-flight: accept on req0, assert rst the next cycle for 2 cycles -> no rvalid0 afterwards; all outputs at reset values.
 f. Deassert after accept: req0 pulses for 1 cycle with lock0=1 -> FSM back in ARB next cycle; the read still returns.
